// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op/state encodings for the RV32M multiply/divide unit
package muldiv_unit_pkg;

  localparam int WORD_WIDTH = 32;

  // funct3 order of the M extension
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - unsigned restoring divider, one quotient bit per cycle
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;

  logic [WIDTH-1:0] step_rem, step_quo, step_dvs, next_rem, next_quo;
  logic [WIDTH:0]   shifted, diff;

  // One restoring step. The start cycle already performs step 1 on the fresh
  // operands so that WIDTH steps finish after WIDTH edges including the start edge.
  always_comb begin
    step_rem = start ? '0 : rem_q;
    step_quo = start ? dividend : quo_q;
    step_dvs = start ? divisor : dvs_q;
    shifted  = {step_rem, step_quo[WIDTH-1]};
    diff     = shifted - {1'b0, step_dvs};
    next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    next_quo = {step_quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Iteration control: load on start, step while running, pulse done after the last step
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (kill) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = next_rem;
      quo_d = next_quo;
      dvs_d = divisor;
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = next_rem;
      quo_d = next_quo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M execution unit (MUL*/DIV*/REM*)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = WORD_WIDTH,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_EN      = 1
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             div_zero
);

  md_state_e        state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       mcnt_q, mcnt_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             div_zero_q, div_zero_d;

  logic [2:0]         src_op;
  logic [WIDTH-1:0]   src_a, src_b, mul_res;
  logic               a_sgn, b_sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  logic             is_signed, is_rem, b_zero, ovf, take_special;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;

  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem, fix_quo, fix_rem, fix_res;

  // Multiplier: with MUL_LATENCY=1 the product comes straight from the request
  // inputs, otherwise from the operands latched at accept.
  always_comb begin
    src_op  = (state_q == ST_IDLE) ? op : op_q;
    src_a   = (state_q == ST_IDLE) ? op_a : a_q;
    src_b   = (state_q == ST_IDLE) ? op_b : b_q;
    a_sgn   = ((src_op == MD_MULH) || (src_op == MD_MULHSU)) && src_a[WIDTH-1];
    b_sgn   = (src_op == MD_MULH) && src_b[WIDTH-1];
    a_ext   = {{WIDTH{a_sgn}}, src_a};
    b_ext   = {{WIDTH{b_sgn}}, src_b};
    prod    = a_ext * b_ext;
    mul_res = (src_op == MD_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  // Division request decode: magnitudes for the divider and one-cycle special cases
  always_comb begin
    is_signed    = ~op[0];
    is_rem       = op[1];
    b_zero       = (op_b == '0);
    ovf          = is_signed && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    abs_a        = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    abs_b        = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    take_special = (DIV_EN == 0) || b_zero || ovf;
    if (DIV_EN == 0)  special_res = '0;
    else if (b_zero)  special_res = is_rem ? op_a : '1;
    else if (ovf)     special_res = is_rem ? '0 : op_a;
    else              special_res = '0;
  end

  // Sign fix-up of the unsigned divider result
  always_comb begin
    fix_quo = quo_neg_q ? -div_quo : div_quo;
    fix_rem = rem_neg_q ? -div_rem : div_rem;
    fix_res = op_q[1] ? fix_rem : fix_quo;
  end

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clk      (CLK),
    .rst_n    (nrst),
    .start    (div_start),
    .kill     (kill),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Next-state and datapath update; kill overrides everything and leaves res alone
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    mcnt_d      = mcnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    res_d       = res_q;
    out_valid_d = 1'b0;
    div_zero_d  = div_zero_q;
    div_start   = 1'b0;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d       = op;
            a_d        = op_a;
            b_d        = op_b;
            div_zero_d = 1'b0;
            quo_neg_d  = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rem_neg_d  = is_signed && op_a[WIDTH-1];
            if (!op[2]) begin
              if (MUL_LATENCY == 1) begin
                state_d     = ST_DONE;
                res_d       = mul_res;
                out_valid_d = 1'b1;
              end else begin
                state_d = ST_MUL;
                mcnt_d  = 2'd1;
              end
            end else if (take_special) begin
              state_d     = ST_DONE;
              res_d       = special_res;
              div_zero_d  = b_zero;
              out_valid_d = 1'b1;
            end else begin
              state_d   = ST_DIV;
              div_start = 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mcnt_q == 2'(MUL_LATENCY - 1)) begin
            state_d     = ST_DONE;
            res_d       = mul_res;
            out_valid_d = 1'b1;
          end else begin
            mcnt_d = mcnt_q + 2'd1;
          end
        end
        ST_DIV: begin
          if (div_done) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d     = ST_DONE;
          res_d       = fix_res;
          out_valid_d = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mcnt_q      <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mcnt_q      <= mcnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (latency 2/1/4, divider on/on/off)
module tb_muldiv_unit;

  logic        clk, nrst;
  logic        in_valid [3];
  logic        kill [3];
  logic [2:0]  op [3];
  logic [31:0] op_a [3], op_b [3];
  logic        in_ready [3], busy [3], out_valid [3], div_zero [3];
  logic [31:0] res [3];

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: latency 2 with divider, 1: latency 1 with divider, 2: latency 4 without divider
  for (genvar g = 0; g < 3; g++) begin : g_dut
    muldiv_unit #(
      .WIDTH      (32),
      .MUL_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4)),
      .DIV_EN     (g == 2 ? 0 : 1)
    ) u_dut (
      .CLK      (clk),
      .nrst     (nrst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .op       (op[g]),
      .op_a     (op_a[g]),
      .op_b     (op_b[g]),
      .kill     (kill[g]),
      .busy     (busy[g]),
      .out_valid(out_valid[g]),
      .res      (res[g]),
      .div_zero (div_zero[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input bit div_en);
    logic [63:0] p;
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (!div_en) return 32'd0;
        if (b == 32'd0) return (o == 3'd6 || o == 3'd7) ? a : 32'hFFFF_FFFF;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return (o == 3'd4) ? a : 32'd0;
        case (o)
          3'd4:    return $signed(a) / $signed(b);
          3'd5:    return a / b;
          3'd6:    return $signed(a) % $signed(b);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int model_lat(input int d, input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (o < 3'd4) return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    if (d == 2 || b == 32'd0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic expect_push(input int d, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b);
    exp_t e;
    e.res = model_res(o, a, b, d != 2);
    e.dz  = (o >= 3'd4) && (b == 32'd0);
    e.lat = model_lat(d, o, a, b);
    sb_q.push_back(e);
  endtask

  // called just after the accept edge; counts cycles until the out_valid pulse
  task automatic wait_check(input int d, input string tag);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      seen = out_valid[d];
    end
    chk({tag, " out_valid seen"}, 32'(seen), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " res"}, res[d], e.res);
      chk({tag, " div_zero"}, 32'(div_zero[d]), 32'(e.dz));
      chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
      last_res[d] = e.res;
    end
  endtask

  task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    expect_push(d, o, a, b);
    @(negedge clk);
    chk({tag, " in_ready before"}, 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    op[d]       = o;
    op_a[d]     = a;
    op_b[d]     = b;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    op[d]       = 3'($urandom);
    op_a[d]     = $urandom;
    op_b[d]     = $urandom;
    wait_check(d, tag);
    @(negedge clk);
    chk({tag, " pulse ends"}, 32'(out_valid[d]), 32'd0);
    chk({tag, " in_ready after"}, 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    nrst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      kill[d]     = 1'b0;
      op[d]       = 3'd0;
      op_a[d]     = 32'd0;
      op_b[d]     = 32'd0;
      last_res[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset in_ready", 32'(in_ready[d]), 32'd1);
      chk("reset busy", 32'(busy[d]), 32'd0);
      chk("reset out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset res", res[d], 32'd0);
      chk("reset div_zero", 32'(div_zero[d]), 32'd0);
    end
    nrst = 1'b1;

    run_op(0, 3'd1, 32'hFFFF_FFFE, 32'd3, "mulh");
    run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, "mul");
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(0, 3'd5, 32'd100, 32'd7, "divu");
    run_op(0, 3'd7, 32'd100, 32'd7, "remu");
    run_op(0, 3'd5, 32'd5, 32'd0, "divu by zero");
    run_op(0, 3'd6, 32'd5, 32'd0, "rem by zero");
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");

    // kill at cycle 10 of a divide
    @(negedge clk);
    in_valid[0] = 1'b1;
    op[0]       = 3'd4;
    op_a[0]     = 32'hFFFF_FFF9;
    op_b[0]     = 32'd2;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("kill pre out_valid", 32'(out_valid[0]), 32'd0);
    end
    @(negedge clk);
    kill[0] = 1'b1;
    @(posedge clk);
    #1;
    kill[0] = 1'b0;
    @(negedge clk);
    chk("kill in_ready", 32'(in_ready[0]), 32'd1);
    chk("kill busy", 32'(busy[0]), 32'd0);
    chk("kill out_valid", 32'(out_valid[0]), 32'd0);
    chk("kill res held", res[0], last_res[0]);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu after kill");

    // kill in the accept cycle suppresses the accept
    @(negedge clk);
    in_valid[0] = 1'b1;
    kill[0]     = 1'b1;
    op[0]       = 3'd0;
    op_a[0]     = 32'd9;
    op_b[0]     = 32'd9;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    kill[0]     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("kill accept busy", 32'(busy[0]), 32'd0);
      chk("kill accept out_valid", 32'(out_valid[0]), 32'd0);
    end
    chk("kill accept res", res[0], last_res[0]);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    in_valid[0] = 1'b1;
    op[0]       = 3'd5;
    op_a[0]     = 32'd1000;
    op_b[0]     = 32'd3;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async reset busy", 32'(busy[0]), 32'd0);
    chk("async reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("async reset res", res[0], 32'd0);
    chk("async reset in_ready", 32'(in_ready[0]), 32'd1);
    for (int d = 0; d < 3; d++) last_res[d] = 32'd0;
    @(negedge clk);
    nrst = 1'b1;
    run_op(0, 3'd0, 32'd6, 32'd7, "mul after reset");

    // a request held high while busy waits until the cycle after DONE
    expect_push(0, 3'd5, 32'd100, 32'd7);
    expect_push(0, 3'd0, 32'd6, 32'd7);
    @(negedge clk);
    in_valid[0] = 1'b1;
    op[0]       = 3'd5;
    op_a[0]     = 32'd100;
    op_b[0]     = 32'd7;
    @(posedge clk);
    #1;
    op[0]   = 3'd0;
    op_a[0] = 32'd6;
    op_b[0] = 32'd7;
    wait_check(0, "held divu");
    chk("held busy in done", 32'(busy[0]), 32'd1);
    chk("held in_ready in done", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    chk("held in_ready after done", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_check(0, "held mul");

    // random sweep over all ops on every configuration
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 14; i++) begin
        ro = 3'($urandom_range(0, 7));
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 5))
          0: rb = 32'd0;
          1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
          2: rb = 32'($urandom_range(1, 15));
          default: ;
        endcase
        run_op(d, ro, ra, rb, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
